// File: rtl/pipe_stage_buf_pkg.sv
// ---------------------------------------------------------------------------
// lc3b_types -- shared types and constants for the LC-3b pipeline stage
// buffers.
//
// Contents:
//   PIPE_DEPTH_MAX  : largest legal stage buffer depth (8)
//   stage_payload_t : packed stage payload (control word plus data fields),
//                     cast to the buffer's PAYLOAD_W where it is instantiated
//   ptr_width()     : pointer width for a given depth (never less than 1 bit)
// ---------------------------------------------------------------------------
package lc3b_types;

    localparam int PIPE_DEPTH_MAX = 8;

    // 64-bit stage payload: control word followed by the data fields
    // carried between pipeline stages.
    typedef struct packed {
        logic [15:0] ctrl;     // decoded control word
        logic [15:0] pc;       // PC of the instruction in this stage
        logic [15:0] ir;       // instruction register
        logic [15:0] alu_out;  // ALU / address result
    } stage_payload_t;

    // A depth-1 buffer still needs a 1-bit pointer so that no
    // zero-width vectors appear.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf_if -- upstream/downstream handshake bundle of a stage buffer.
//
// Handshake: a payload moves across a side at a rising clk edge exactly when
// that side's valid and ready are both 1. Valid does not depend on ready. The
// buffer's ready and valid depend only on its registered state.
//
// Signals:
//   in_valid / in_ready / in_data    : upstream side (into the buffer)
//   out_valid / out_ready / out_data : downstream side (out of the buffer)
//
// Modports:
//   slave  : the buffer itself
//   master : the environment (upstream producer plus downstream consumer)
// ---------------------------------------------------------------------------
interface pipe_stage_buf_if #(
    parameter int PAYLOAD_W = 64
);
    logic                 in_valid;
    logic                 in_ready;
    logic [PAYLOAD_W-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [PAYLOAD_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_ptr.sv
// ---------------------------------------------------------------------------
// pipe_stage_ptr -- modulo-DEPTH wrapping pointer.
//
// Ports:
//   clk   : clock, rising edge
//   clear : synchronous clear to 0 (wins over inc)
//   inc   : advance by one, wrapping DEPTH-1 -> 0
//   ptr   : current pointer value
//
// Wrapping is by explicit compare, so non-power-of-two depths work.
// ---------------------------------------------------------------------------
module pipe_stage_ptr
    import lc3b_types::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            if (ptr == PTR_W'(DEPTH - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf -- small FIFO buffer between two pipeline stages.
//
// Parameters:
//   PAYLOAD_W : payload width (default 64, the size of stage_payload_t)
//   DEPTH     : number of entries, 1..PIPE_DEPTH_MAX
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset; empties the buffer
//   bus    : pipe_stage_buf_if.slave handshake bundle
//   count  : current occupancy
//   flush  : (only with PIPE_STAGE_FLUSH_EN) empties the buffer like reset;
//            used by redirect logic to squash wrong-path contents
//
// Configuration macro: PIPE_STAGE_FLUSH_EN adds the flush port.
//
// Behaviour: strict FIFO, one cycle latency, no bypass. in_ready/out_valid
// come from the registered count only, so there is no combinational path
// from out_ready to in_ready; a full buffer does not accept a push in the
// same cycle as a pop. out_data is read straight from storage.
// ---------------------------------------------------------------------------
module pipe_stage_buf
    import lc3b_types::*;
#(
    parameter int PAYLOAD_W = 64,
    parameter int DEPTH     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    pipe_stage_buf_if.slave            bus,
`ifdef PIPE_STAGE_FLUSH_EN
    input  logic                       flush,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = ptr_width(DEPTH);

    logic [PAYLOAD_W-1:0] mem [0:DEPTH-1];
    logic [CNT_W-1:0]     count_q;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic                 push;
    logic                 pop;
    logic                 clear;
    logic                 squash;

`ifdef PIPE_STAGE_FLUSH_EN
    assign squash = flush;
`else
    assign squash = 1'b0;
`endif

    // Reset and flush both return the buffer to empty; reset ranks higher
    // but the effect is identical, so one clear term covers both.
    assign clear = reset | squash;

    assign bus.in_ready  = (count_q < CNT_W'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = mem[rd_ptr];
    assign count         = count_q;

    assign push = bus.in_valid  & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is never cleared; entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    pipe_stage_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .clear (clear),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    pipe_stage_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .clear (clear),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buf -- bench for pipe_stage_buf.
//
// Three buffers (DEPTH 1, 2, 3) share the same stimulus. Each has a queue
// model: a push is accepted when the queue holds fewer than DEPTH entries, a
// pop when it is non-empty and out_ready is 1, and reset/flush empty it.
// Directed steps cover the named scenarios; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_pipe_stage_buf;

    typedef logic [63:0] q_t[$];

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset     = 1'b1;
    logic        in_valid  = 1'b0;
    logic [63:0] in_data   = '0;
    logic        out_ready = 1'b0;
    logic        flush     = 1'b0;

    logic [0:0] cnt1;
    logic [1:0] cnt2;
    logic [1:0] cnt3;

    pipe_stage_buf_if #(.PAYLOAD_W(64)) if1 ();
    pipe_stage_buf_if #(.PAYLOAD_W(64)) if2 ();
    pipe_stage_buf_if #(.PAYLOAD_W(64)) if3 ();

    assign if1.in_valid = in_valid;  assign if1.in_data = in_data;  assign if1.out_ready = out_ready;
    assign if2.in_valid = in_valid;  assign if2.in_data = in_data;  assign if2.out_ready = out_ready;
    assign if3.in_valid = in_valid;  assign if3.in_data = in_data;  assign if3.out_ready = out_ready;

`ifdef PIPE_STAGE_FLUSH_EN
    pipe_stage_buf #(.PAYLOAD_W(64), .DEPTH(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave), .flush(flush), .count(cnt1));
    pipe_stage_buf #(.PAYLOAD_W(64), .DEPTH(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave), .flush(flush), .count(cnt2));
    pipe_stage_buf #(.PAYLOAD_W(64), .DEPTH(3)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave), .flush(flush), .count(cnt3));
`else
    pipe_stage_buf #(.PAYLOAD_W(64), .DEPTH(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave), .count(cnt1));
    pipe_stage_buf #(.PAYLOAD_W(64), .DEPTH(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave), .count(cnt2));
    pipe_stage_buf #(.PAYLOAD_W(64), .DEPTH(3)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave), .count(cnt3));
`endif

    // scoreboard state
    q_t q1, q2, q3;
    logic [63:0] exp_q[$];   // expected DEPTH=3 pop order in the wrap test
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Queue model of one edge with the current inputs.
    task automatic model_edge(input q_t qi, input int depth, output q_t qo);
        bit do_push;
        bit do_pop;
        qo = qi;
        if (reset || flush) begin
            qo.delete();
        end else begin
            do_push = in_valid && (qi.size() < depth);
            do_pop  = (qi.size() != 0) && out_ready;
            if (do_pop)  void'(qo.pop_front());
            if (do_push) qo.push_back(in_data);
        end
    endtask

    task automatic check_dut(input string tag, input int depth, input q_t q,
                             input logic ov, input logic ir, input logic [63:0] od,
                             input logic [63:0] cnt);
        check({tag, "_count"},     cnt, 64'(q.size()));
        check({tag, "_out_valid"}, {63'b0, ov}, {63'b0, q.size() != 0});
        check({tag, "_in_ready"},  {63'b0, ir}, {63'b0, q.size() < depth});
        if (q.size() != 0) check({tag, "_out_data"}, od, q[0]);
    endtask

    // Advance one clock: update models, take the edge, check #1 later.
    task automatic tick();
        q_t n1, n2, n3;
        model_edge(q1, 1, n1);
        model_edge(q2, 2, n2);
        model_edge(q3, 3, n3);
        @(posedge clk);
        q1 = n1; q2 = n2; q3 = n3;
        #1;
        check_dut("d1", 1, q1, if1.out_valid, if1.in_ready, if1.out_data, 64'(cnt1));
        check_dut("d2", 2, q2, if2.out_valid, if2.in_ready, if2.out_data, 64'(cnt2));
        check_dut("d3", 3, q3, if3.out_valid, if3.in_ready, if3.out_data, 64'(cnt3));
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        logic [63:0] prev;
        int          next_item;
        int          cyc;

        // reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset_count2", 64'(cnt2), 64'd0);
        check("reset_in_ready2", {63'b0, if2.in_ready}, 64'd1);

        // fill DEPTH=2 with 0xA, 0xB while downstream stalls
        drive(1'b1, 64'hA, 1'b0); tick();
        drive(1'b1, 64'hB, 1'b0); tick();
        drive(1'b0, 64'hFFFF, 1'b0); tick();
        check("full_count2", 64'(cnt2), 64'd2);
        check("full_in_ready2", {63'b0, if2.in_ready}, 64'd0);
        check("full_head2", if2.out_data, 64'hA);
        tick();
        check("stall_stable2", if2.out_data, 64'hA);

        // full with pop and offered 0xC: 0xA leaves, 0xC waits a cycle
        drive(1'b1, 64'hC, 1'b1); tick();
        check("fullpop_count2", 64'(cnt2), 64'd1);
        check("fullpop_head2", if2.out_data, 64'hB);
        drive(1'b1, 64'hC, 1'b0); tick();
        check("retry_count2", 64'(cnt2), 64'd2);

        // steady stream at count=1: output is input delayed by one
        drive(1'b0, '0, 1'b0);
        reset = 1'b1; tick(); reset = 1'b0;
        drive(1'b1, 64'h100, 1'b0); tick();
        prev = 64'h100;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, {$urandom, $urandom}, 1'b1);
            check("stream_head2", if2.out_data, prev);
            prev = in_data;
            tick();
            check("stream_count2", 64'(cnt2), 64'd1);
        end

        // DEPTH=3 wrap: items 1..7 must come out in order
        drive(1'b0, '0, 1'b0);
        reset = 1'b1; tick(); reset = 1'b0;
        exp_q.delete();
        for (int i = 1; i <= 7; i++) exp_q.push_back(64'(i));
        next_item = 1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            drive(next_item <= 7, 64'(next_item), 1'($urandom_range(0, 1)));
            if (if3.out_valid && out_ready) begin
                check("wrap_order3", if3.out_data, exp_q.pop_front());
            end
            if (in_valid && if3.in_ready) next_item++;
            tick();
            cyc++;
        end
        check("wrap_done3", 64'(exp_q.size()), 64'd0);

        // reset overrides a push while holding two entries
        drive(1'b1, 64'h21, 1'b0); tick();
        drive(1'b1, 64'h22, 1'b0); tick();
        check("prereset_count2", 64'(cnt2), 64'd2);
        drive(1'b1, 64'h23, 1'b1);
        reset = 1'b1; tick(); reset = 1'b0;
        drive(1'b0, '0, 1'b1);
        check("rst_count2", 64'(cnt2), 64'd0);
        check("rst_out_valid2", {63'b0, if2.out_valid}, 64'd0);
        check("rst_in_ready2", {63'b0, if2.in_ready}, 64'd1);
        tick();
        check("rst_nothing_out2", {63'b0, if2.out_valid}, 64'd0);

`ifdef PIPE_STAGE_FLUSH_EN
        // flush with a same-edge push of 0xD
        drive(1'b1, 64'h31, 1'b0); tick();
        drive(1'b1, 64'h32, 1'b0); tick();
        drive(1'b1, 64'hD, 1'b1);
        flush = 1'b1; tick(); flush = 1'b0;
        check("flush_count2", 64'(cnt2), 64'd0);
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_d2", {63'b0, if2.out_valid}, 64'd0);
        end
`endif

        // randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            reset = ($urandom_range(0, 49) == 0);
`ifdef PIPE_STAGE_FLUSH_EN
            flush = ($urandom_range(0, 39) == 0);
`endif
            tick();
        end
        reset = 1'b0;
        flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
